// File: rtl/exe_stage.sv
// Execute stage: latches the ID operand bundle, runs the one-hot ALU and offers the result to MEM.
// Optional forwarding port enabled by defining EXE_FWD_EN; otherwise the exe_fwd_* ports are tied to 0.
module alu (
   input  logic [12:0] alu_control,
   input  logic [31:0] alu_src1,
   input  logic [31:0] alu_src2,
   output logic [31:0] alu_result
);
   logic [4:0] sa_s;
   assign sa_s = alu_src1[4:0];

   // Priority chain: the highest set control bit selects the operation; no bits set yields zero.
   always_comb begin
      alu_result = 32'd0;
      if (alu_control[12]) begin
         alu_result = ~(alu_src1 & alu_src2);
      end else if (alu_control[11]) begin
         alu_result = alu_src1 + alu_src2;
      end else if (alu_control[10]) begin
         alu_result = alu_src1 - alu_src2;
      end else if (alu_control[9]) begin
         alu_result = {31'd0, ($signed(alu_src1) < $signed(alu_src2))};
      end else if (alu_control[8]) begin
         alu_result = {31'd0, (alu_src1 < alu_src2)};
      end else if (alu_control[7]) begin
         alu_result = alu_src1 & alu_src2;
      end else if (alu_control[6]) begin
         alu_result = ~(alu_src1 | alu_src2);
      end else if (alu_control[5]) begin
         alu_result = alu_src1 | alu_src2;
      end else if (alu_control[4]) begin
         alu_result = alu_src1 ^ alu_src2;
      end else if (alu_control[3]) begin
         alu_result = alu_src2 << sa_s;
      end else if (alu_control[2]) begin
         alu_result = alu_src2 >> sa_s;
      end else if (alu_control[1]) begin
         alu_result = $unsigned($signed(alu_src2) >>> sa_s);
      end else if (alu_control[0]) begin
         alu_result = {alu_src2[15:0], 16'd0};
      end else begin
         alu_result = 32'd0;
      end
   end
endmodule

module exe_stage #(
   parameter int DEST_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_to_exe_valid,
   output logic              exe_allowin,
   input  logic [12:0]       id_alu_control,
   input  logic [31:0]       id_alu_src1,
   input  logic [31:0]       id_alu_src2,
   input  logic [DEST_W-1:0] id_dest,
   input  logic [31:0]       id_pc,
   input  logic              exe_flush,
   input  logic              mem_allowin,
   output logic              exe_to_mem_valid,
   output logic [31:0]       exe_result,
   output logic [DEST_W-1:0] exe_dest,
   output logic [31:0]       exe_pc,
   output logic              exe_fwd_valid,
   output logic [DEST_W-1:0] exe_fwd_dest,
   output logic [31:0]       exe_fwd_data,
   output logic [31:0]       exe_retire_cnt
);
   logic              exe_valid_r;
   logic [12:0]       ctrl_r;
   logic [31:0]       src1_r;
   logic [31:0]       src2_r;
   logic [DEST_W-1:0] dest_r;
   logic [31:0]       pc_r;
   logic [31:0]       retire_cnt_r;
   logic              allowin_s;
   logic              accept_s;
   logic              handoff_s;
   logic [31:0]       result_s;

   // Every op finishes in one cycle, so the stage frees up whenever MEM takes the bundle.
   assign allowin_s = !exe_valid_r || mem_allowin;
   assign accept_s  = id_to_exe_valid && allowin_s;
   assign handoff_s = exe_valid_r && mem_allowin;

   // Stage occupancy; flush wins over a same-cycle accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         exe_valid_r <= 1'b0;
      end else if (exe_flush) begin
         exe_valid_r <= 1'b0;
      end else if (allowin_s) begin
         exe_valid_r <= id_to_exe_valid;
      end
   end

   // Bundle registers load only on an accepted handshake and hold while stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_r <= 13'd0;
         src1_r <= 32'd0;
         src2_r <= 32'd0;
         dest_r <= {DEST_W{1'b0}};
         pc_r   <= 32'd0;
      end else if (accept_s) begin
         ctrl_r <= id_alu_control;
         src1_r <= id_alu_src1;
         src2_r <= id_alu_src2;
         dest_r <= id_dest;
         pc_r   <= id_pc;
      end
   end

   // Counts bundles MEM actually took, including one flushed in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         retire_cnt_r <= 32'd0;
      end else if (handoff_s) begin
         retire_cnt_r <= retire_cnt_r + 32'd1;
      end
   end

   alu u_alu (
      .alu_control (ctrl_r),
      .alu_src1    (src1_r),
      .alu_src2    (src2_r),
      .alu_result  (result_s)
   );

   assign exe_allowin      = allowin_s;
   assign exe_to_mem_valid = exe_valid_r;
   assign exe_result       = result_s;
   assign exe_dest         = dest_r;
   assign exe_pc           = pc_r;
   assign exe_retire_cnt   = retire_cnt_r;

`ifdef EXE_FWD_EN
   assign exe_fwd_valid = exe_valid_r && (dest_r != {DEST_W{1'b0}});
   assign exe_fwd_dest  = dest_r;
   assign exe_fwd_data  = result_s;
`else
   assign exe_fwd_valid = 1'b0;
   assign exe_fwd_dest  = {DEST_W{1'b0}};
   assign exe_fwd_data  = 32'd0;
`endif
endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: a driver pushes expected results, a negedge monitor pops and compares.
module tb_exe_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_to_exe_valid = 1'b0;
   logic        exe_allowin;
   logic [12:0] id_alu_control = 13'd0;
   logic [31:0] id_alu_src1 = 32'd0;
   logic [31:0] id_alu_src2 = 32'd0;
   logic [4:0]  id_dest = 5'd0;
   logic [31:0] id_pc = 32'd0;
   logic        exe_flush = 1'b0;
   logic        mem_allowin = 1'b1;
   logic        exe_to_mem_valid;
   logic [31:0] exe_result;
   logic [4:0]  exe_dest;
   logic [31:0] exe_pc;
   logic        exe_fwd_valid;
   logic [4:0]  exe_fwd_dest;
   logic [31:0] exe_fwd_data;
   logic [31:0] exe_retire_cnt;

   exe_stage #(.DEST_W(5)) dut (
      .clk(clk), .rst(rst), .id_to_exe_valid(id_to_exe_valid), .exe_allowin(exe_allowin),
      .id_alu_control(id_alu_control), .id_alu_src1(id_alu_src1), .id_alu_src2(id_alu_src2),
      .id_dest(id_dest), .id_pc(id_pc), .exe_flush(exe_flush), .mem_allowin(mem_allowin),
      .exe_to_mem_valid(exe_to_mem_valid), .exe_result(exe_result), .exe_dest(exe_dest),
      .exe_pc(exe_pc), .exe_fwd_valid(exe_fwd_valid), .exe_fwd_dest(exe_fwd_dest),
      .exe_fwd_data(exe_fwd_data), .exe_retire_cnt(exe_retire_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  dest;
      logic [31:0] pc;
   } exp_t;

   exp_t        exp_q[$];
   logic        m_valid = 1'b0;
   logic [31:0] exp_cnt = 32'd0;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h", nm, act, req);
      end
   endtask

   // Reference ALU straight from the operation table (one-hot or zero control only).
   function automatic logic [31:0] ref_alu(input logic [12:0] c, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(a[4:0]);
      case (c)
         13'h1000: return ~(a & b);
         13'h0800: return a + b;
         13'h0400: return a - b;
         13'h0200: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         13'h0100: return (a < b) ? 32'd1 : 32'd0;
         13'h0080: return a & b;
         13'h0040: return ~(a | b);
         13'h0020: return a | b;
         13'h0010: return a ^ b;
         13'h0008: return b << sh;
         13'h0004: return b >> sh;
         13'h0002: return $unsigned($signed(b) >>> sh);
         13'h0001: return b * 32'd65536;
         default:  return 32'd0;
      endcase
   endfunction

   // One cycle of stimulus; the model advances at the edge the DUT samples.
   task automatic step(input logic v, input logic [12:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic [31:0] p, input logic ma, input logic fl);
      exp_t e;
      logic allow;
      id_to_exe_valid = v; id_alu_control = c; id_alu_src1 = a; id_alu_src2 = b;
      id_dest = d; id_pc = p; mem_allowin = ma; exe_flush = fl;
      @(posedge clk);
      allow = !m_valid || ma;
      if (m_valid && ma) exp_cnt = exp_cnt + 32'd1;
      if (fl && m_valid && !ma && exp_q.size() > 0) void'(exp_q.pop_front());
      if (fl) begin
         m_valid = 1'b0;
      end else if (allow) begin
         m_valid = v;
         if (v) begin
            e.res = ref_alu(c, a, b); e.dest = d; e.pc = p;
            exp_q.push_back(e);
         end
      end
      #1;
   endtask

   task automatic idle(input logic ma);
      step(1'b0, 13'd0, 32'd0, 32'd0, 5'd0, 32'd0, ma, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      id_to_exe_valid = 1'b0; exe_flush = 1'b0; mem_allowin = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      m_valid = 1'b0; exp_cnt = 32'd0; exp_q.delete();
      rst = 1'b0;
   endtask

   task automatic check_reset_state();
      @(negedge clk);
      check("rst_allowin", {31'd0, exe_allowin}, 32'd1);
      check("rst_to_mem_valid", {31'd0, exe_to_mem_valid}, 32'd0);
      check("rst_retire_cnt", exe_retire_cnt, 32'd0);
      check("rst_result", exe_result, 32'd0);
      check("rst_dest", {27'd0, exe_dest}, 32'd0);
      check("rst_pc", exe_pc, 32'd0);
      check("rst_fwd_valid", {31'd0, exe_fwd_valid}, 32'd0);
      check("rst_fwd_data", exe_fwd_data, 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares handshake, counter and the held bundle; pops on every hand-off.
   always @(negedge clk) begin
      if (!rst) begin
         check("allowin", {31'd0, exe_allowin}, {31'd0, (!m_valid || mem_allowin)});
         check("to_mem_valid", {31'd0, exe_to_mem_valid}, {31'd0, m_valid});
         check("retire_cnt", exe_retire_cnt, exp_cnt);
         if (m_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL scoreboard_empty: actual=valid bundle required=no bundle");
            end else begin
               check("result", exe_result, exp_q[0].res);
               check("dest", {27'd0, exe_dest}, {27'd0, exp_q[0].dest});
               check("pc", exe_pc, exp_q[0].pc);
`ifdef EXE_FWD_EN
               check("fwd_valid", {31'd0, exe_fwd_valid}, {31'd0, (exp_q[0].dest != 5'd0)});
               check("fwd_dest", {27'd0, exe_fwd_dest}, {27'd0, exp_q[0].dest});
               check("fwd_data", exe_fwd_data, exp_q[0].res);
`else
               check("fwd_valid_off", {31'd0, exe_fwd_valid}, 32'd0);
               check("fwd_data_off", exe_fwd_data, 32'd0);
`endif
               if (mem_allowin) void'(exp_q.pop_front());
            end
         end else begin
            check("fwd_valid_idle", {31'd0, exe_fwd_valid}, 32'd0);
         end
      end
   end

   initial begin
      logic [12:0] c;
      int          sel;
      do_reset();
      check_reset_state();

      // add, then hand-off
      step(1'b1, 13'h0800, 32'd5, 32'd7, 5'd3, 32'hBFC00000, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // back-pressure: sub held for 3 stalled cycles while ID waits with the next bundle
      step(1'b1, 13'h0400, 32'd1, 32'd2, 5'd4, 32'hBFC00004, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         step(1'b1, 13'h0020, 32'h00F0, 32'h0F00, 5'd6, 32'hBFC00008, 1'b0, 1'b0);
      step(1'b1, 13'h0020, 32'h00F0, 32'h0F00, 5'd6, 32'hBFC00008, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // flush with MEM stalled
      step(1'b1, 13'h0100, 32'd1, 32'hFFFFFFFF, 5'd7, 32'hBFC0000C, 1'b0, 1'b0);
      step(1'b0, 13'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1);
      idle(1'b0);
      idle(1'b1);

      // flush and hand-off in the same cycle
      step(1'b1, 13'h0080, 32'hFF00FF00, 32'h0FF00FF0, 5'd8, 32'hBFC00010, 1'b1, 1'b0);
      step(1'b1, 13'h0010, 32'd3, 32'd5, 5'd2, 32'hBFC00014, 1'b1, 1'b1);
      idle(1'b1);

      // sra with dest 0 and dest 9
      step(1'b1, 13'h0002, 32'd4, 32'h80000000, 5'd0, 32'hBFC00018, 1'b1, 1'b0);
      step(1'b1, 13'h0002, 32'd4, 32'h80000000, 5'd9, 32'hBFC0001C, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // counter wrap: preload then stream three lui ops
      force dut.retire_cnt_r = 32'hFFFFFFFE;
      #1;
      release dut.retire_cnt_r;
      exp_cnt = 32'hFFFFFFFE;
      for (int i = 0; i < 3; i++)
         step(1'b1, 13'h0001, 32'd0, 32'h00001234, 5'd10, 32'hBFC00020 + 32'(i * 4), 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         sel = int'($urandom_range(0, 13));
         c = (sel == 13) ? 13'd0 : (13'd1 << sel);
         step(($urandom_range(0, 3) != 0), c, $urandom(), $urandom(),
              5'($urandom_range(0, 31)), $urandom(),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
      end
      idle(1'b1);
      idle(1'b1);

      // reset in the middle of a stalled bundle
      step(1'b1, 13'h0800, 32'd9, 32'd9, 5'd1, 32'hBFC00100, 1'b0, 1'b0);
      idle(1'b0);
      do_reset();
      check_reset_state();
      idle(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
